// File: rtl/soc_boot_ctrl.sv
// Reset and core-select sequencer in front of the SoC: debounces the select switch,
// wraps every core swap or soft reset in an SoC reset window, and times each run.
module soc_boot_ctrl #(
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned PRE_CYCLES  = 16,
  parameter int unsigned RST_HOLD    = 64,
  parameter logic        SEL_DEFAULT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_btn_i,
  input  logic        soft_rst_req_i,
  input  logic        done_i,
  output logic        soc_rst_o,
  output logic        chip_sel_o,
  output logic        busy_o,
  output logic [31:0] run_cycles_o,
  output logic        done_valid_o
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned RUN_W = 32;

  // INIT counts one extra cycle: the partial cycle before the first edge out of reset
  // is not part of the hold window.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(RST_HOLD);
  localparam logic [RUN_W-1:0] RUN_MAX   = '1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_RUN,
    ST_PRE,
    ST_SWAP,
    ST_POST
  } state_e;

  logic             sync_meta_q;
  logic             sync_q;
  logic             sel_db_q,  sel_db_d;
  logic [CNT_W-1:0] db_cnt_q,  db_cnt_d;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] ph_cnt_q,  ph_cnt_d;
  logic             soc_rst_q, soc_rst_d;
  logic             chip_sel_q, chip_sel_d;
  logic             busy_q,    busy_d;

  logic [RUN_W-1:0] run_cnt_q,    run_cnt_d;
  logic [RUN_W-1:0] run_cycles_q, run_cycles_d;
  logic             done_valid_q, done_valid_d;
  logic             done_q,       done_d;

  // Switch synchronizer and debouncer; active in every state.
  always_comb begin
    sel_db_d = sel_db_q;
    db_cnt_d = '0;
    if (sync_q != sel_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        sel_db_d = sync_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta_q <= SEL_DEFAULT;
      sync_q      <= SEL_DEFAULT;
      sel_db_q    <= SEL_DEFAULT;
      db_cnt_q    <= '0;
    end else begin
      sync_meta_q <= sel_btn_i;
      sync_q      <= sync_meta_q;
      sel_db_q    <= sel_db_d;
      db_cnt_q    <= db_cnt_d;
    end
  end

  // Sequencer next state; registered outputs follow the state being entered.
  always_comb begin
    state_d    = state_q;
    ph_cnt_d   = ph_cnt_q + CNT_W'(1);
    chip_sel_d = chip_sel_q;
    case (state_q)
      ST_INIT: begin
        if (ph_cnt_q == INIT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        ph_cnt_d = '0;
        if ((sel_db_q != chip_sel_q) || soft_rst_req_i) state_d = ST_PRE;
      end
      ST_PRE: begin
        if (ph_cnt_q == PRE_LAST) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        chip_sel_d = sel_db_q;
        state_d    = ST_POST;
      end
      ST_POST: begin
        if (ph_cnt_q == POST_LAST) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    if (state_d != state_q) ph_cnt_d = '0;
    soc_rst_d = (state_d == ST_RUN);
    busy_d    = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      ph_cnt_q   <= '0;
      soc_rst_q  <= 1'b0;
      chip_sel_q <= SEL_DEFAULT;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      ph_cnt_q   <= ph_cnt_d;
      soc_rst_q  <= soc_rst_d;
      chip_sel_q <= chip_sel_d;
      busy_q     <= busy_d;
    end
  end

  // Run-length measurement: only the first done_i rising edge of a run is captured.
  always_comb begin
    run_cnt_d    = run_cnt_q;
    run_cycles_d = run_cycles_q;
    done_valid_d = done_valid_q;
    done_d       = 1'b0;
    if (state_q == ST_RUN) begin
      done_d = done_i;
      if (run_cnt_q != RUN_MAX) run_cnt_d = run_cnt_q + RUN_W'(1);
      if (done_i && !done_q && !done_valid_q) begin
        run_cycles_d = run_cnt_q;
        done_valid_d = 1'b1;
      end
    end
    if (state_d != ST_RUN) done_d = 1'b0;
    if ((state_d == ST_RUN) && (state_q != ST_RUN)) run_cnt_d = '0;
    if ((state_d == ST_PRE) && (state_q != ST_PRE)) done_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_q    <= '0;
      run_cycles_q <= '0;
      done_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      run_cnt_q    <= run_cnt_d;
      run_cycles_q <= run_cycles_d;
      done_valid_q <= done_valid_d;
      done_q       <= done_d;
    end
  end

  assign soc_rst_o    = soc_rst_q;
  assign chip_sel_o   = chip_sel_q;
  assign busy_o       = busy_q;
  assign run_cycles_o = run_cycles_q;
  assign done_valid_o = done_valid_q;

endmodule

// File: tb/tb_soc_boot_ctrl.sv
// Self-checking bench for soc_boot_ctrl: expected waveforms are derived from the
// documented latencies (sync + debounce, pre/post hold windows, run capture rule).
module tb_soc_boot_ctrl;

  localparam int unsigned DB      = 8;
  localparam int unsigned PRE     = 4;
  localparam int unsigned HOLD    = 64;
  localparam logic        SEL_DEF = 1'b0;

  logic        clk;
  logic        rst;
  logic        sel_btn_i;
  logic        soft_rst_req_i;
  logic        done_i;
  logic        soc_rst_o;
  logic        chip_sel_o;
  logic        busy_o;
  logic [31:0] run_cycles_o;
  logic        done_valid_o;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          run_start   = 0;
  logic        exp_chip    = SEL_DEF;
  logic        exp_valid   = 1'b0;
  logic [31:0] exp_rc      = '0;

  soc_boot_ctrl #(
    .DB_CYCLES  (DB),
    .PRE_CYCLES (PRE),
    .RST_HOLD   (HOLD),
    .SEL_DEFAULT(SEL_DEF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sel_btn_i     (sel_btn_i),
    .soft_rst_req_i(soft_rst_req_i),
    .done_i        (done_i),
    .soc_rst_o     (soc_rst_o),
    .chip_sel_o    (chip_sel_o),
    .busy_o        (busy_o),
    .run_cycles_o  (run_cycles_o),
    .done_valid_o  (done_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick(1);
  endtask

  // Hold reset, check reset values, release and check the power-up hold window.
  task automatic test_reset();
    int   e0;
    logic exp_r;
    rst = 1'b0; sel_btn_i = SEL_DEF; soft_rst_req_i = 1'b0; done_i = 1'b0;
    exp_chip = SEL_DEF; exp_valid = 1'b0; exp_rc = '0;
    tick(3);
    vectors++; if (soc_rst_o !== 1'b0) begin miscompares++; $display("FAIL reset_soc_rst got=%b exp=0", soc_rst_o); end
    vectors++; if (chip_sel_o !== SEL_DEF) begin miscompares++; $display("FAIL reset_chip_sel got=%b exp=%b", chip_sel_o, SEL_DEF); end
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL reset_busy got=%b exp=1", busy_o); end
    vectors++; if (run_cycles_o !== 32'd0) begin miscompares++; $display("FAIL reset_run_cycles got=%0d exp=0", run_cycles_o); end
    vectors++; if (done_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_done_valid got=%b exp=0", done_valid_o); end
    rst = 1'b1;
    e0  = cyc;
    for (int k = 0; k < int'(HOLD) + 3; k++) begin
      tick(1);
      exp_r = (cyc >= e0 + int'(HOLD) + 1);
      vectors++; if (soc_rst_o !== exp_r) begin miscompares++; $display("FAIL powerup_soc_rst cyc=%0d got=%b exp=%b", cyc - e0, soc_rst_o, exp_r); end
      vectors++; if (chip_sel_o !== SEL_DEF) begin miscompares++; $display("FAIL powerup_chip_sel cyc=%0d got=%b exp=%b", cyc - e0, chip_sel_o, SEL_DEF); end
      vectors++; if (busy_o !== !exp_r) begin miscompares++; $display("FAIL powerup_busy cyc=%0d got=%b exp=%b", cyc - e0, busy_o, !exp_r); end
    end
    run_start = e0 + int'(HOLD) + 1;
  endtask

  // done_i rises L cycles after RUN entry; later pulses must not disturb the capture.
  task automatic test_run_measure(input int L);
    wait_to(run_start + L);
    vectors++; if (soc_rst_o !== 1'b1) begin miscompares++; $display("FAIL meas_in_run got=%b exp=1", soc_rst_o); end
    vectors++; if (done_valid_o !== 1'b0) begin miscompares++; $display("FAIL meas_valid_early got=%b exp=0", done_valid_o); end
    done_i = 1'b1;
    tick(1);
    exp_rc = 32'(L); exp_valid = 1'b1;
    vectors++; if (run_cycles_o !== exp_rc) begin miscompares++; $display("FAIL meas_capture got=%0d exp=%0d", run_cycles_o, exp_rc); end
    vectors++; if (done_valid_o !== 1'b1) begin miscompares++; $display("FAIL meas_valid got=%b exp=1", done_valid_o); end
    tick($urandom_range(1, 4));
    done_i = 1'b0;
    tick($urandom_range(2, 5));
    done_i = 1'b1;
    tick(2);
    done_i = 1'b0;
    tick(1);
    vectors++; if (run_cycles_o !== exp_rc) begin miscompares++; $display("FAIL meas_second_pulse got=%0d exp=%0d", run_cycles_o, exp_rc); end
    vectors++; if (done_valid_o !== 1'b1) begin miscompares++; $display("FAIL meas_valid_hold got=%b exp=1", done_valid_o); end
  endtask

  // One soft-reset pulse in RUN, a second one during POST, and done_i pulsed outside RUN.
  task automatic test_soft_reset();
    int   e, p, d0;
    logic exp_r;
    e  = cyc;
    p  = e + int'($urandom_range(6, 68));
    d0 = e + int'($urandom_range(8, 40));
    soft_rst_req_i = 1'b1;
    exp_valid = 1'b0;
    while (cyc < e + int'(PRE + 1 + HOLD) + 6) begin
      tick(1);
      soft_rst_req_i = (cyc == p);
      done_i         = (cyc >= d0) && (cyc < d0 + 4);
      exp_r = !((cyc >= e + 1) && (cyc < e + 1 + int'(PRE + 1 + HOLD)));
      vectors++; if (soc_rst_o !== exp_r) begin miscompares++; $display("FAIL soft_soc_rst t=%0d got=%b exp=%b", cyc - e, soc_rst_o, exp_r); end
      vectors++; if (chip_sel_o !== exp_chip) begin miscompares++; $display("FAIL soft_chip_sel t=%0d got=%b exp=%b", cyc - e, chip_sel_o, exp_chip); end
      vectors++; if (busy_o !== !exp_r) begin miscompares++; $display("FAIL soft_busy t=%0d got=%b exp=%b", cyc - e, busy_o, !exp_r); end
      vectors++; if (done_valid_o !== exp_valid) begin miscompares++; $display("FAIL soft_done_valid t=%0d got=%b exp=%b", cyc - e, done_valid_o, exp_valid); end
      vectors++; if (run_cycles_o !== exp_rc) begin miscompares++; $display("FAIL soft_run_cycles t=%0d got=%0d exp=%0d", cyc - e, run_cycles_o, exp_rc); end
    end
    run_start = e + 1 + int'(PRE + 1 + HOLD);
  endtask

  // Switch bounces faster than the debounce window and ends where it started.
  task automatic test_bounce(input bit fixed5);
    logic b0;
    int   n, iv;
    b0 = sel_btn_i;
    n  = 2 * int'($urandom_range(3, 6));
    for (int t = 0; t <= n; t++) begin
      if (t < n) sel_btn_i = ~sel_btn_i;
      iv = fixed5 ? 5 : int'($urandom_range(1, DB - 1));
      if (t == n) iv = int'(DB) + 4;
      for (int j = 0; j < iv; j++) begin
        tick(1);
        vectors++; if (soc_rst_o !== 1'b1) begin miscompares++; $display("FAIL bounce_soc_rst t=%0d got=%b exp=1", t, soc_rst_o); end
        vectors++; if (chip_sel_o !== exp_chip) begin miscompares++; $display("FAIL bounce_chip_sel t=%0d got=%b exp=%b", t, chip_sel_o, exp_chip); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL bounce_busy t=%0d got=%b exp=0", t, busy_o); end
      end
    end
    vectors++; if (sel_btn_i !== b0) begin miscompares++; $display("FAIL bounce_end_level got=%b exp=%b", sel_btn_i, b0); end
  endtask

  // Clean switch edge; optionally a soft request lands in the same cycle as the swap.
  task automatic test_swap(input bit with_soft);
    int   e, f, c, r;
    logic nv, old_v, exp_r, exp_c, exp_dv;
    e = cyc; old_v = exp_chip; nv = ~exp_chip;
    f = e + 2 + int'(DB) + 1;
    c = f + int'(PRE) + 1;
    r = c + int'(HOLD);
    sel_btn_i = nv;
    while (cyc < r + 4) begin
      tick(1);
      soft_rst_req_i = with_soft && (cyc == f - 1);
      exp_r  = !((cyc >= f) && (cyc < r));
      exp_c  = (cyc >= c) ? nv : old_v;
      exp_dv = (cyc >= f) ? 1'b0 : exp_valid;
      vectors++; if (soc_rst_o !== exp_r) begin miscompares++; $display("FAIL swap_soc_rst t=%0d got=%b exp=%b", cyc - e, soc_rst_o, exp_r); end
      vectors++; if (chip_sel_o !== exp_c) begin miscompares++; $display("FAIL swap_chip_sel t=%0d got=%b exp=%b", cyc - e, chip_sel_o, exp_c); end
      vectors++; if (busy_o !== !exp_r) begin miscompares++; $display("FAIL swap_busy t=%0d got=%b exp=%b", cyc - e, busy_o, !exp_r); end
      vectors++; if (done_valid_o !== exp_dv) begin miscompares++; $display("FAIL swap_done_valid t=%0d got=%b exp=%b", cyc - e, done_valid_o, exp_dv); end
      vectors++; if (run_cycles_o !== exp_rc) begin miscompares++; $display("FAIL swap_run_cycles t=%0d got=%0d exp=%0d", cyc - e, run_cycles_o, exp_rc); end
    end
    exp_chip = nv; exp_valid = 1'b0; run_start = r;
  endtask

  // Switch flipped back during POST: one RUN cycle, then an immediate second swap.
  task automatic test_pending_swap();
    int   e, f, c, r1, b, c2, r2;
    logic orig, nv, exp_r, exp_c;
    e = cyc; orig = exp_chip; nv = ~exp_chip;
    f  = e + 2 + int'(DB) + 1;
    c  = f + int'(PRE) + 1;
    r1 = c + int'(HOLD);
    b  = c + int'($urandom_range(0, HOLD - 2 - DB - 1));
    c2 = r1 + 1 + int'(PRE) + 1;
    r2 = c2 + int'(HOLD);
    sel_btn_i = nv;
    while (cyc < r2 + 4) begin
      tick(1);
      if (cyc == b) sel_btn_i = orig;
      exp_r = (cyc < f) || (cyc == r1) || (cyc >= r2);
      exp_c = ((cyc >= c) && (cyc < c2)) ? nv : orig;
      vectors++; if (soc_rst_o !== exp_r) begin miscompares++; $display("FAIL pend_soc_rst t=%0d got=%b exp=%b", cyc - e, soc_rst_o, exp_r); end
      vectors++; if (chip_sel_o !== exp_c) begin miscompares++; $display("FAIL pend_chip_sel t=%0d got=%b exp=%b", cyc - e, chip_sel_o, exp_c); end
      vectors++; if (busy_o !== !exp_r) begin miscompares++; $display("FAIL pend_busy t=%0d got=%b exp=%b", cyc - e, busy_o, !exp_r); end
    end
    exp_valid = 1'b0; run_start = r2;
  endtask

  // Asynchronous reset asserted mid-cycle while POST is in progress.
  task automatic test_mid_reset();
    int e;
    e = cyc;
    soft_rst_req_i = 1'b1;
    tick(1);
    soft_rst_req_i = 1'b0;
    wait_to(e + int'($urandom_range(7, 60)));
    vectors++; if (soc_rst_o !== 1'b0) begin miscompares++; $display("FAIL midrst_pre_soc_rst got=%b exp=0", soc_rst_o); end
    vectors++; if (chip_sel_o !== exp_chip) begin miscompares++; $display("FAIL midrst_pre_chip_sel got=%b exp=%b", chip_sel_o, exp_chip); end
    #3;
    rst = 1'b0;
    sel_btn_i = SEL_DEF;
    #1;
    vectors++; if (soc_rst_o !== 1'b0) begin miscompares++; $display("FAIL midrst_soc_rst got=%b exp=0", soc_rst_o); end
    vectors++; if (chip_sel_o !== SEL_DEF) begin miscompares++; $display("FAIL midrst_chip_sel got=%b exp=%b", chip_sel_o, SEL_DEF); end
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL midrst_busy got=%b exp=1", busy_o); end
    vectors++; if (run_cycles_o !== 32'd0) begin miscompares++; $display("FAIL midrst_run_cycles got=%0d exp=0", run_cycles_o); end
    vectors++; if (done_valid_o !== 1'b0) begin miscompares++; $display("FAIL midrst_done_valid got=%b exp=0", done_valid_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      test_soft_reset();
      test_run_measure((cyc - run_start) + int'($urandom_range(1, 300)));
    end
  endtask

  initial begin
    rst = 1'b0; sel_btn_i = SEL_DEF; soft_rst_req_i = 1'b0; done_i = 1'b0;
    test_reset();
    test_run_measure(1000);
    test_soft_reset();
    test_run_measure((cyc - run_start) + int'($urandom_range(1, 300)));
    test_bounce(1'b1);
    test_bounce(1'b0);
    test_swap(1'b1);
    test_pending_swap();
    test_run_measure((cyc - run_start) + int'($urandom_range(1, 300)));
    test_back_to_back();
    test_mid_reset();
    test_reset();
    test_swap(1'b0);
    test_run_measure((cyc - run_start) + int'($urandom_range(1, 300)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/soc_boot_ctrl.md
# soc_boot_ctrl

Reset and core-select sequencer that sits directly upstream of the SoC top and drives its `rst` and `chip_sel` inputs. It debounces a raw core-select switch and brackets every core swap with a reset window, so the SoC never changes masters while a core is running. It also honours a soft-reset request. While the selected core runs, it measures the run length in clock cycles up to the core's done indication.

## Interface
Parameters:
- `DB_CYCLES`, default 1000000: number of consecutive stable cycles required before a switch change is accepted.
- `PRE_CYCLES`, default 16: cycles the SoC reset is held before `chip_sel` changes.
- `RST_HOLD`, default 64: cycles the SoC reset is held after `chip_sel` changes, and after power-up.
- `SEL_DEFAULT`, default 1'b0: value of `chip_sel_o` out of reset.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `sel_btn_i`  in  1  raw core-select switch; asynchronous to `clk`.
- `soft_rst_req_i`  in  1  single-cycle request for a SoC reset with no core swap.
- `done_i`  in  1  run-finished indication from the SoC; active-high level.
- `soc_rst_o`  out  1  SoC reset; active-low; registered.
- `chip_sel_o`  out  1  core select to the SoC; registered.
- `busy_o`  out  1  high whenever the FSM is not in RUN.
- `run_cycles_o`  out  32  latched length of the last run, in cycles.
- `done_valid_o`  out  1  `run_cycles_o` holds a valid measurement.

## Operation
- Input sync: `sel_btn_i` passes through a 2-FF synchronizer to give `sel_sync`.
- Debounce:
  - A counter increments while `sel_sync != sel_db` and clears whenever they are equal.
  - When the count reaches `DB_CYCLES-1`, `sel_db <= sel_sync` and the counter clears.
  - Debouncing runs in every state.
- FSM states: INIT, RUN, PRE, SWAP, POST.
  - INIT (entered on reset): `soc_rst_o=0`, `chip_sel_o=SEL_DEFAULT`. Count `RST_HOLD` cycles, then go to RUN.
  - RUN: `soc_rst_o=1`.
    - If `sel_db != chip_sel_o` or `soft_rst_req_i=1`, go to PRE.
    - A swap condition and a soft request in the same cycle produce a single PRE entry.
  - PRE: `soc_rst_o=0`. Count `PRE_CYCLES` cycles, then go to SWAP.
  - SWAP: lasts 1 cycle. `chip_sel_o <= sel_db` (a no-op for a soft reset), then go to POST.
  - POST: `soc_rst_o=0`. Count `RST_HOLD` cycles, then go to RUN.
  - On RUN entry, a swap pending from a switch change made during PRE/SWAP/POST is taken immediately: PRE begins the next cycle.
  - `soft_rst_req_i` outside RUN is ignored (reset is already in progress).
- Run counter:
  - 32-bit; cleared on every RUN entry; increments each RUN cycle; saturates at 0xFFFFFFFF.
  - On the first rising edge of `done_i` in RUN: `run_cycles_o <=` counter value and `done_valid_o <= 1`.
  - Later edges in the same run are ignored.
  - `done_valid_o` clears on PRE entry. `run_cycles_o` keeps its value until the next capture.
  - `done_i` is ignored outside RUN. Edge detection uses a registered copy of `done_i`, and that register is cleared on leaving RUN.
- Reset values: `soc_rst_o=0`, `chip_sel_o=SEL_DEFAULT`, `busy_o=1`, `run_cycles_o=0`, `done_valid_o=0`, `sel_db=SEL_DEFAULT`, all counters 0.

## Timing
- Asserting `rst` low forces every output to its reset value immediately, in any state, including mid-swap.
- Release of `rst`: `soc_rst_o` rises exactly `RST_HOLD` cycles after the first rising `clk` edge with `rst` high.
- Switch latency: a clean `sel_btn_i` edge reaches `sel_db` after 2 (sync) + `DB_CYCLES` cycles.
- Swap latency:
  - `soc_rst_o` falls 1 cycle after `sel_db` changes.
  - `chip_sel_o` changes `PRE_CYCLES+1` cycles after that fall.
  - `soc_rst_o` rises `RST_HOLD` cycles after `chip_sel_o` changes.
- Invariant: `chip_sel_o` changes only while `soc_rst_o=0`.
- Soft reset: `soc_rst_o` is low for exactly `PRE_CYCLES+1+RST_HOLD` cycles.
- Capture: `run_cycles_o` equals the number of RUN cycles before the cycle in which `done_i` is first sampled high; `done_valid_o` rises 1 cycle after that sample.

## Test plan
- Power-up, `RST_HOLD=64`: release `rst` -> `soc_rst_o` stays 0 for 64 cycles then goes 1; `chip_sel_o=0` throughout; `busy_o` falls with the `soc_rst_o` rise.
- Swap, `DB_CYCLES=8`, `PRE_CYCLES=4`: `sel_btn_i` 0->1 held -> `soc_rst_o` falls 11 cycles after the edge; `chip_sel_o`=1 5 cycles later; `soc_rst_o`=1 64 cycles after that.
- Bounce: `sel_btn_i` toggles every 5 cycles with `DB_CYCLES=8` -> `sel_db` never changes; `soc_rst_o` stays 1; `chip_sel_o` unchanged.
- Soft reset: `soft_rst_req_i` pulsed once in RUN -> `soc_rst_o` low for 69 cycles; `chip_sel_o` unchanged. A second pulse during POST -> no extension.
- Run measurement: `done_i` rises 1000 cycles after RUN entry -> `run_cycles_o=1000`, `done_valid_o=1`. A second `done_i` pulse -> value unchanged. A subsequent soft reset -> `done_valid_o=0`.
- Mid-operation reset and a pending swap:
  - Assert `rst` during POST -> all outputs return to reset values asynchronously.
  - Separately, flip the switch back during POST -> after RUN entry, PRE is entered immediately and `chip_sel_o` returns to its original value.
